mips_test_value_tx: RTL and testbench

Debug-output transmitter for the single-cycle MIPS core. It watches the core's 16-bit `test_value` bus and queues every change in a small FIFO. Each queued word is serialized on a one-wire UART-style line, so results can leave the chip or FPGA without probing internal nets. It sits beside the `MIPS` top level and is the outbound end of the `test_value` observation path that the bench drives today.

---
 rtl/mips_dbg_pkg.sv | 16 +
 rtl/dbg_sync_fifo.sv | 64 ++++++
 rtl/mips_test_value_tx.sv | 169 ++++++++++++++++
 tb/tb_mips_test_value_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared types and framing constants for the MIPS debug-output transmitter.
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;
    localparam int   BITS_PER_BYTE  = 8;
    localparam int   BYTES_PER_WORD = 2;

endpackage

// File: rtl/dbg_sync_fifo.sv
// Small synchronous FIFO; fullness comes from an occupancy count, so pointers
// may simply wrap and a push into a full FIFO is fine when a pop shares the edge.
module dbg_sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             do_push_s, do_pop_s;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == LW'(0));
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // Accept/reject decisions and next pointer/occupancy values.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mips_test_value_tx.sv
// Watches test_value for changes, queues each new value and shifts it out as
// two UART-style bytes (high byte first, LSB first within each byte).
module mips_test_value_tx
    import mips_dbg_pkg::*;
#(
    parameter  int DATA_WIDTH   = 16,
    parameter  int FIFO_DEPTH   = 4,
    parameter  int CLKS_PER_BIT = 8,
    localparam int LEVEL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] test_value,
    output logic                  TX,
    output logic                  busy,
    output logic [LEVEL_W-1:0]    fifo_level,
    output logic                  overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BITS_PER_BYTE);

    tx_state_e                state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [BW-1:0]            bit_idx_q, bit_idx_d;
    logic                     byte_sel_q, byte_sel_d;
    logic [BITS_PER_BYTE-1:0] shift_q, shift_d;
    logic [BITS_PER_BYTE-1:0] lo_byte_q, lo_byte_d;
    logic [DATA_WIDTH-1:0]    last_value_q, last_value_d;
    logic                     overflow_q, overflow_d;
    logic                     tx_q, tx_d;
    logic                     busy_q, busy_d;

    logic                  push_s, pop_s, bit_end_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic [DATA_WIDTH-1:0] fifo_rdata_s;

    dbg_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (test_value),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level)
    );

    assign TX       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

    // Change detector, overflow flag and serializer next-state logic.
    always_comb begin
        push_s       = (test_value != last_value_q);
        last_value_d = test_value;
        bit_end_s    = (cnt_q == CW'(CLKS_PER_BIT - 1));
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        byte_sel_d   = byte_sel_q;
        shift_d      = shift_q;
        lo_byte_d    = lo_byte_q;
        pop_s        = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    shift_d    = fifo_rdata_s[DATA_WIDTH-1 -: BITS_PER_BYTE];
                    lo_byte_d  = fifo_rdata_s[BITS_PER_BYTE-1:0];
                    byte_sel_d = 1'b0;
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (bit_idx_q == BW'(BITS_PER_BYTE - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                        shift_d   = {1'b0, shift_q[BITS_PER_BYTE-1:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    cnt_d = '0;
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        shift_d    = lo_byte_q;
                        state_d    = START;
                    end else if (!fifo_empty_s) begin
                        // Next word starts with no idle gap after the stop bit.
                        pop_s      = 1'b1;
                        shift_d    = fifo_rdata_s[DATA_WIDTH-1 -: BITS_PER_BYTE];
                        lo_byte_d  = fifo_rdata_s[BITS_PER_BYTE-1:0];
                        byte_sel_d = 1'b0;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line level follows the state being entered so TX stays registered.
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = STOP_BIT;
            default: tx_d = STOP_BIT;
        endcase
        busy_d     = (state_d != IDLE);
        overflow_d = overflow_q | (push_s & fifo_full_s & ~pop_s);
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            byte_sel_q   <= 1'b0;
            shift_q      <= '0;
            lo_byte_q    <= '0;
            last_value_q <= '0;
            overflow_q   <= 1'b0;
            tx_q         <= STOP_BIT;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_sel_q   <= byte_sel_d;
            shift_q      <= shift_d;
            lo_byte_q    <= lo_byte_d;
            last_value_q <= last_value_d;
            overflow_q   <= overflow_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_mips_test_value_tx.sv
// Bench for mips_test_value_tx: a line decoder recovers bytes from TX and each
// scenario compares them, plus timing points, against values it derives itself.
module tb_mips_test_value_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   test_value = 16'h0000;
    logic          tx;
    logic          busy;
    logic [LW-1:0] fifo_level;
    logic          overflow;

    int          checks = 0;
    int          errors = 0;
    int          frame_err = 0;
    logic [7:0]  byte_q[$];
    logic [15:0] cur = 16'h0000;

    always #5 clk = ~clk;

    mips_test_value_tx #(
        .DATA_WIDTH   (16),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .test_value (test_value),
        .TX         (tx),
        .busy       (busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    // Line decoder: detects a start bit, samples every bit mid-period.
    initial begin
        logic [7:0] b;
        logic       st, sp;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                sp = tx;
                byte_q.push_back(b);
                if (st !== 1'b0 || sp !== 1'b1) frame_err++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        test_value = 16'h0000;
        tick(2);
        checks += 4;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (fifo_level !== LW'(0)) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        rst = 1'b0;
        cur = 16'h0000;
        tick(50);
        checks += 2;
        if (byte_q.size() != 0) begin errors++; $display("FAIL reset_no_frame got %0d bytes want 0", byte_q.size()); end
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_idle_tx got %b want 1", tx); end
    endtask

    task automatic test_single_word();
        logic [7:0] exp[$];
        byte_q.delete();
        test_value = 16'h1234;
        cur = 16'h1234;
        tick();
        checks += 2;
        if (fifo_level !== LW'(1)) begin errors++; $display("FAIL single_level_p got %0d want 1", fifo_level); end
        if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_p got %b want 1", tx); end
        tick();
        checks += 3;
        if (fifo_level !== LW'(0)) begin errors++; $display("FAIL single_level_p1 got %0d want 0", fifo_level); end
        if (tx !== 1'b0) begin errors++; $display("FAIL single_tx_fall got %b want 0", tx); end
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise got %b want 1", busy); end
        tick(79);
        checks += 1;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_p80 got %b want 1", busy); end
        tick();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_p81 got %b want 0", busy); end
        if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_idle got %b want 1", tx); end
        tick(5);
        exp = '{8'h12, 8'h34};
        checks += 2;
        if (frame_err != 0) begin errors++; $display("FAIL single_framing got %0d errs want 0", frame_err); end
        if (byte_q.size() != exp.size()) begin
            errors++; $display("FAIL single_count got %0d want %0d", byte_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (byte_q[i] !== exp[i]) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, byte_q[i], exp[i]); end
            end
        end
    endtask

    task automatic test_no_change();
        byte_q.delete();
        test_value = 16'h00AB;
        cur = 16'h00AB;
        tick(200);
        checks++;
        if (byte_q.size() != 2) begin
            errors++; $display("FAIL nochange_count got %0d want 2", byte_q.size());
        end else begin
            checks += 2;
            if (byte_q[0] !== 8'h00) begin errors++; $display("FAIL nochange_hi got %h want 00", byte_q[0]); end
            if (byte_q[1] !== 8'hAB) begin errors++; $display("FAIL nochange_lo got %h want ab", byte_q[1]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        int busy_low = 0;
        byte_q.delete();
        test_value = 16'h0001;
        tick();
        test_value = 16'h0002;
        cur = 16'h0002;
        tick();
        checks += 3;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_rise got %b want 1", busy); end
        if (tx !== 1'b0) begin errors++; $display("FAIL b2b_tx_fall got %b want 0", tx); end
        if (fifo_level !== LW'(1)) begin errors++; $display("FAIL b2b_level got %0d want 1", fifo_level); end
        for (int c = 2; c <= 160; c++) begin
            tick();
            if (busy !== 1'b1) busy_low++;
            if (c == 80) begin
                checks++;
                if (tx !== 1'b1) begin errors++; $display("FAIL b2b_last_stop got %b want 1", tx); end
            end
            if (c == 81) begin
                checks++;
                if (tx !== 1'b0) begin errors++; $display("FAIL b2b_second_start got %b want 0", tx); end
            end
        end
        checks++;
        if (busy_low != 0) begin errors++; $display("FAIL b2b_busy_gap got %0d low cycles want 0", busy_low); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall got %b want 0", busy); end
        tick(5);
        exp = '{8'h00, 8'h01, 8'h00, 8'h02};
        checks++;
        if (byte_q.size() != exp.size()) begin
            errors++; $display("FAIL b2b_count got %0d want %0d", byte_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (byte_q[i] !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, byte_q[i], exp[i]); end
            end
        end
    endtask

    // Bursts of at most FIFO_DEPTH+1 changes from idle always fit without loss.
    task automatic test_random();
        logic [15:0] words[$];
        logic [15:0] v;
        int          k;
        int          exp_level;
        for (int r = 0; r < 6; r++) begin
            byte_q.delete();
            words.delete();
            k = $urandom_range(1, DEPTH + 1);
            for (int i = 0; i < k; i++) begin
                v = 16'($urandom);
                while (v == cur) v = 16'($urandom);
                test_value = v;
                cur = v;
                words.push_back(v);
                tick();
            end
            exp_level = (k == 1) ? 1 : k - 1;
            checks++;
            if (fifo_level !== LW'(exp_level)) begin errors++; $display("FAIL rand%0d_level got %0d want %0d", r, fifo_level, exp_level); end
            tick(k * 20 * CPB + 20);
            checks += 3;
            if (overflow !== 1'b0) begin errors++; $display("FAIL rand%0d_overflow got %b want 0", r, overflow); end
            if (frame_err != 0) begin errors++; $display("FAIL rand%0d_framing got %0d errs want 0", r, frame_err); end
            if (byte_q.size() != 2 * k) begin
                errors++; $display("FAIL rand%0d_count got %0d want %0d", r, byte_q.size(), 2 * k);
            end else begin
                for (int i = 0; i < k; i++) begin
                    checks++;
                    if ({byte_q[2*i], byte_q[2*i+1]} !== words[i]) begin
                        errors++; $display("FAIL rand%0d_word%0d got %h%h want %h", r, i, byte_q[2*i], byte_q[2*i+1], words[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] vals[6];
        byte_q.delete();
        for (int i = 0; i < 6; i++) vals[i] = cur + 16'(i + 1);
        for (int i = 0; i < 6; i++) begin
            test_value = vals[i];
            tick();
            if (i == 1) begin
                checks++;
                if (fifo_level !== LW'(1)) begin errors++; $display("FAIL ovf_level_e2 got %0d want 1", fifo_level); end
            end
            if (i == 4) begin
                checks += 2;
                if (fifo_level !== LW'(4)) begin errors++; $display("FAIL ovf_level_e5 got %0d want 4", fifo_level); end
                if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
            end
        end
        cur = vals[5];
        checks += 2;
        if (fifo_level !== LW'(4)) begin errors++; $display("FAIL ovf_level_e6 got %0d want 4", fifo_level); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        tick(5 * 20 * CPB + 20);
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        if (byte_q.size() != 10) begin
            errors++; $display("FAIL ovf_count got %0d want 10", byte_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if ({byte_q[2*i], byte_q[2*i+1]} !== vals[i]) begin
                    errors++; $display("FAIL ovf_word%0d got %h%h want %h", i, byte_q[2*i], byte_q[2*i+1], vals[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        if (cur == 16'h5555) begin
            test_value = 16'h5554;
            cur = 16'h5554;
            tick(200);
        end
        byte_q.delete();
        test_value = 16'h5555;
        tick();
        tick(10);
        rst = 1'b1;
        test_value = 16'h0000;
        tick();
        checks += 4;
        if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b want 1", tx); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        if (fifo_level !== LW'(0)) begin errors++; $display("FAIL midrst_level got %0d want 0", fifo_level); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow got %b want 0", overflow); end
        rst = 1'b0;
        cur = 16'h0000;
        tick(60);
        byte_q.delete();
        frame_err = 0;
        tick(100);
        checks += 2;
        if (byte_q.size() != 0) begin errors++; $display("FAIL midrst_silent got %0d bytes want 0", byte_q.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_busy got %b want 0", busy); end
        test_value = 16'h5555;
        cur = 16'h5555;
        tick(100);
        checks += 2;
        if (frame_err != 0) begin errors++; $display("FAIL midrst_framing got %0d errs want 0", frame_err); end
        if (byte_q.size() != 2) begin
            errors++; $display("FAIL midrst_count got %0d want 2", byte_q.size());
        end else begin
            checks++;
            if ({byte_q[0], byte_q[1]} !== 16'h5555) begin
                errors++; $display("FAIL midrst_word got %h%h want 5555", byte_q[0], byte_q[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_no_change();
        test_back_to_back();
        test_random();
        test_overflow();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
